// File: rtl/otp_pad_scheduler_if.sv
// ---------------------------------------------------------------------------
// otp_pad_scheduler_if
//   Bundles the one-time-pad scheduler's requester, PRNG and result signals.
//   master : encrypt/decrypt requesters plus the PRNG source (drive requests
//            and the current pad byte, observe grants and results).
//   slave  : the scheduler itself.
//   Signals:
//     enc_valid/enc_data/enc_ready          encrypt request channel
//     dec_valid/dec_data/dec_idx/dec_ready  decrypt request channel
//     prn/prn_step                          PRNG byte in, advance strobe out
//     out_valid/out_data/out_idx/
//     out_is_dec/out_err                    one-cycle result strobe
//     slot_valid/full                       pad occupancy status
// ---------------------------------------------------------------------------
interface otp_pad_scheduler_if #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
);
  logic              enc_valid;
  logic [DATA_W-1:0] enc_data;
  logic              enc_ready;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_data;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_ready;
  logic [DATA_W-1:0] prn;
  logic              prn_step;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_is_dec;
  logic              out_err;
  logic [DEPTH-1:0]  slot_valid;
  logic              full;

  modport master (
    output enc_valid, enc_data, dec_valid, dec_data, dec_idx, prn,
    input  enc_ready, dec_ready, prn_step,
    input  out_valid, out_data, out_idx, out_is_dec, out_err, slot_valid, full
  );

  modport slave (
    input  enc_valid, enc_data, dec_valid, dec_data, dec_idx, prn,
    output enc_ready, dec_ready, prn_step,
    output out_valid, out_data, out_idx, out_is_dec, out_err, slot_valid, full
  );
endinterface

// File: rtl/otp_pad_scheduler.sv
// ---------------------------------------------------------------------------
// otp_pad_scheduler
//   Sequences one-time-pad use between an encrypt requester and a decrypt
//   requester. Pads are pulled from the PRNG only when an encrypt is
//   accepted, stored in strict ring order, and each pad is consumed by
//   exactly one decrypt. At most one request is accepted per cycle; results
//   appear one cycle after acceptance.
//   Ports:
//     clk_i    rising-edge clock
//     reset_i  synchronous active-high reset
//     bus      otp_pad_scheduler_if.slave (requests, PRNG, results, status)
// ---------------------------------------------------------------------------
module otp_pad_scheduler #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  otp_pad_scheduler_if.slave bus
);

  // Pad storage holds no meaningful data until its slot_valid bit is set,
  // so it is deliberately left out of reset.
  logic [DATA_W-1:0] pad_q [DEPTH];

  logic [DEPTH-1:0]  slot_valid_q, slot_valid_d;
  logic [IDX_W-1:0]  wr_ptr_q,     wr_ptr_d;
  logic              prio_q,       prio_d;
  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic [IDX_W-1:0]  out_idx_q,    out_idx_d;
  logic              out_is_dec_q, out_is_dec_d;
  logic              out_err_q,    out_err_d;

  logic enc_ok_s;
  logic dec_ok_s;
  logic enc_gnt_s;
  logic dec_gnt_s;
  logic dec_hit_s;

  // Encrypt is blocked by the registered occupancy of the write slot only;
  // a same-cycle decrypt freeing that slot takes effect next cycle.
  assign enc_ok_s  = bus.enc_valid & ~slot_valid_q[wr_ptr_q] & ~reset_i;
  assign dec_ok_s  = bus.dec_valid & ~reset_i;
  assign dec_hit_s = slot_valid_q[bus.dec_idx];

  // Single-grant arbiter; prio only flips when both sides compete.
  always_comb begin
    enc_gnt_s = 1'b0;
    dec_gnt_s = 1'b0;
    prio_d    = prio_q;
    if (enc_ok_s && dec_ok_s) begin
      if (prio_q == 1'b0) begin
        enc_gnt_s = 1'b1;
      end else begin
        dec_gnt_s = 1'b1;
      end
      prio_d = ~prio_q;
    end else if (enc_ok_s) begin
      enc_gnt_s = 1'b1;
    end else if (dec_ok_s) begin
      dec_gnt_s = 1'b1;
    end else begin
      enc_gnt_s = 1'b0;
      dec_gnt_s = 1'b0;
    end
  end

  // Next-state for occupancy, write pointer and the result registers.
  always_comb begin
    slot_valid_d = slot_valid_q;
    wr_ptr_d     = wr_ptr_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_is_dec_d = out_is_dec_q;
    out_err_d    = out_err_q;
    if (enc_gnt_s) begin
      slot_valid_d[wr_ptr_q] = 1'b1;
      // DEPTH is a power of two, so the natural IDX_W overflow wraps the ring.
      wr_ptr_d     = wr_ptr_q + IDX_W'(1'b1);
      out_valid_d  = 1'b1;
      out_data_d   = bus.prn ^ bus.enc_data;
      out_idx_d    = wr_ptr_q;
      out_is_dec_d = 1'b0;
      out_err_d    = 1'b0;
    end else if (dec_gnt_s) begin
      out_valid_d  = 1'b1;
      out_idx_d    = bus.dec_idx;
      out_is_dec_d = 1'b1;
      if (dec_hit_s) begin
        slot_valid_d[bus.dec_idx] = 1'b0;
        out_data_d = pad_q[bus.dec_idx] ^ bus.dec_data;
        out_err_d  = 1'b0;
      end else begin
        out_data_d = {DATA_W{1'b0}};
        out_err_d  = 1'b1;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_valid_q <= {DEPTH{1'b0}};
      wr_ptr_q     <= {IDX_W{1'b0}};
      prio_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_idx_q    <= {IDX_W{1'b0}};
      out_is_dec_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      prio_q       <= prio_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_is_dec_q <= out_is_dec_d;
      out_err_q    <= out_err_d;
    end
  end

  // Pad capture from the PRNG on encrypt accept.
  always_ff @(posedge clk_i) begin
    if (enc_gnt_s) begin
      pad_q[wr_ptr_q] <= bus.prn;
    end
  end

  assign bus.enc_ready  = enc_gnt_s;
  assign bus.dec_ready  = dec_gnt_s;
  assign bus.prn_step   = enc_gnt_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_is_dec = out_is_dec_q;
  assign bus.out_err    = out_err_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.full       = slot_valid_q[wr_ptr_q];

endmodule

// File: tb/tb_otp_pad_scheduler.sv
// ---------------------------------------------------------------------------
// tb_otp_pad_scheduler
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   all compared against a behavioural model of the pad store (arrays of
//   pads and occupancy flags, a ring write position and a fairness flag).
// ---------------------------------------------------------------------------
module tb_otp_pad_scheduler;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 8;

  logic clk;
  logic reset;

  otp_pad_scheduler_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  otp_pad_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int   m_pad   [DEPTH];
  bit   m_used  [DEPTH];
  int   m_wr;
  bit   m_prio;
  int   e_valid, e_data, e_idx, e_is_dec, e_err;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_bitmap();
    int b = 0;
    for (int i = 0; i < DEPTH; i++) if (m_used[i]) b |= (1 << i);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_used[i] = 1'b0;
    m_wr = 0; m_prio = 1'b0;
    e_valid = 0; e_data = 0; e_idx = 0; e_is_dec = 0; e_err = 0;
  endtask

  // One clock: drive, check handshake/status, advance model, check results.
  task automatic step(input bit ev, input int ed, input bit dv, input int dd,
                      input int di, input int p, input bit rst);
    bit want_enc, want_dec, g_enc, g_dec;
    @(negedge clk);
    reset         = rst;
    bus.enc_valid = ev;
    bus.enc_data  = ed[DATA_W-1:0];
    bus.dec_valid = dv;
    bus.dec_data  = dd[DATA_W-1:0];
    bus.dec_idx   = di[IDX_W-1:0];
    bus.prn       = p[DATA_W-1:0];
    #1;
    want_enc = !rst && ev && !m_used[m_wr];
    want_dec = !rst && dv;
    g_enc = 1'b0; g_dec = 1'b0;
    if (want_enc && want_dec) begin
      if (m_prio) g_dec = 1'b1; else g_enc = 1'b1;
      m_prio = !m_prio;
    end else begin
      g_enc = want_enc;
      g_dec = want_dec;
    end
    check_eq("enc_ready",  int'(bus.enc_ready),  int'(g_enc));
    check_eq("dec_ready",  int'(bus.dec_ready),  int'(g_dec));
    check_eq("prn_step",   int'(bus.prn_step),   int'(g_enc));
    check_eq("full",       int'(bus.full),       int'(m_used[m_wr]));
    check_eq("slot_valid", int'(bus.slot_valid), model_bitmap());
    if (rst) begin
      model_reset();
    end else if (g_enc) begin
      m_pad[m_wr] = p & 8'hFF;
      m_used[m_wr] = 1'b1;
      e_valid = 1; e_data = (p ^ ed) & 8'hFF; e_idx = m_wr; e_is_dec = 0; e_err = 0;
      m_wr = (m_wr + 1) % DEPTH;
    end else if (g_dec) begin
      e_valid = 1; e_idx = di; e_is_dec = 1;
      if (m_used[di]) begin
        e_data = (m_pad[di] ^ dd) & 8'hFF; e_err = 0; m_used[di] = 1'b0;
      end else begin
        e_data = 0; e_err = 1;
      end
    end else begin
      e_valid = 0;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid",  int'(bus.out_valid),  e_valid);
    check_eq("out_data",   int'(bus.out_data),   e_data);
    check_eq("out_idx",    int'(bus.out_idx),    e_idx);
    check_eq("out_is_dec", int'(bus.out_is_dec), e_is_dec);
    check_eq("out_err",    int'(bus.out_err),    e_err);
    check_eq("slot_after", int'(bus.slot_valid), model_bitmap());
  endtask

  task automatic enc(input int ed, input int p);
    step(1'b1, ed, 1'b0, 0, 0, p, 1'b0);
  endtask

  task automatic dec(input int dd, input int di);
    step(1'b0, 0, 1'b1, dd, di, $urandom_range(255), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  int seq [4];

  initial begin
    reset = 1'b1;
    bus.enc_valid = 1'b0; bus.enc_data = '0;
    bus.dec_valid = 1'b0; bus.dec_data = '0; bus.dec_idx = '0; bus.prn = '0;
    repeat (2) @(posedge clk);
    model_reset();
    do_reset();
    check_eq("reset_out_valid", int'(bus.out_valid), 0);
    check_eq("reset_slot_valid", int'(bus.slot_valid), 0);

    // First encrypt: 0x5A ^ 0x3C.
    enc(8'h5A, 8'h3C);
    check_eq("tp1_data", int'(bus.out_data), 8'h66);
    check_eq("tp1_idx",  int'(bus.out_idx),  0);
    check_eq("tp1_slot", int'(bus.slot_valid), 8'h01);

    // Decrypt recovers plaintext, second use is an error.
    dec(8'h66, 0);
    check_eq("tp2_data", int'(bus.out_data), 8'h5A);
    check_eq("tp2_slot", int'(bus.slot_valid), 8'h00);
    dec(8'h66, 0);
    check_eq("tp2_err",  int'(bus.out_err),  1);
    check_eq("tp2_zero", int'(bus.out_data), 0);

    // Fill all slots, then stall, then wrap after freeing slot 0.
    do_reset();
    for (int i = 0; i < DEPTH; i++) enc($urandom_range(255), $urandom_range(255));
    check_eq("tp3_full_map", int'(bus.slot_valid), 8'hFF);
    check_eq("tp3_full", int'(bus.full), 1);
    enc(8'h11, 8'h22);
    check_eq("tp3_stall", int'(bus.out_valid), 0);
    step(1'b1, 8'h11, 1'b1, 8'h00, 0, 8'h22, 1'b0);
    enc(8'h11, 8'h22);
    check_eq("tp3_wrap_idx", int'(bus.out_idx), 0);
    check_eq("tp3_wrap_data", int'(bus.out_data), 8'h33);

    // Free a slot other than wr_ptr's: encrypt stays stalled.
    do_reset();
    for (int i = 0; i < DEPTH; i++) enc($urandom_range(255), $urandom_range(255));
    dec(8'h00, 3);
    for (int i = 0; i < 3; i++) enc(8'h01, 8'h02);
    check_eq("tp4_stall", int'(bus.out_valid), 0);
    check_eq("tp4_map", int'(bus.slot_valid), 8'hF7);

    // Contention alternates starting with encrypt.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, $urandom_range(255), 1'b1, $urandom_range(255), 7, $urandom_range(255), 1'b0);
      seq[i] = int'(bus.out_is_dec);
    end
    check_eq("tp5_seq0", seq[0], 0);
    check_eq("tp5_seq1", seq[1], 1);
    check_eq("tp5_seq2", seq[2], 0);
    check_eq("tp5_seq3", seq[3], 1);

    // Reset right after an encrypt accept drops the result.
    enc(8'hA5, 8'h0F);
    do_reset();
    check_eq("tp6_drop", int'(bus.out_valid), 0);
    check_eq("tp6_map",  int'(bus.slot_valid), 0);
    enc(8'hA5, 8'h0F);
    check_eq("tp6_idx",  int'(bus.out_idx), 0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(99) < 60, $urandom_range(255),
           $urandom_range(99) < 45, $urandom_range(255),
           $urandom_range(DEPTH - 1), $urandom_range(255),
           $urandom_range(199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
